hilo_muldiv_unit: RTL and testbench

- Execute-stage consumer of the 8-bit alucontrol codes for the HI/LO instruction class: EXE_MULT_OP, EXE_MULTU_OP, EXE_DIV_OP, EXE_DIVU_OP, EXE_MTHI_OP, EXE_MTLO_OP, EXE_MFHI_OP and EXE_MFLO_OP.
- Owns the architectural HI/LO registers.
- Multiplies in a single cycle; divides iteratively, stalling the pipeline until done.
- Supplies HI/LO read data to the ALU result mux.

---
 rtl/hilo_muldiv_unit_pkg.sv | 18 +
 rtl/hilo_muldiv_unit_div_radix2.sv | 71 +++++++
 rtl/hilo_muldiv_unit.sv | 136 +++++++++++++
 tb/tb_hilo_muldiv_unit.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/hilo_muldiv_unit_pkg.sv
// Shared op codes and divider FSM encoding for the HI/LO execute unit.
package hilo_muldiv_unit_pkg;
    // Values mirror the core-wide defines.vh op code table.
    localparam logic [7:0] EXE_MFHI_OP  = 8'b0001_0000;
    localparam logic [7:0] EXE_MTHI_OP  = 8'b0001_0001;
    localparam logic [7:0] EXE_MFLO_OP  = 8'b0001_0010;
    localparam logic [7:0] EXE_MTLO_OP  = 8'b0001_0011;
    localparam logic [7:0] EXE_MULT_OP  = 8'b0001_1000;
    localparam logic [7:0] EXE_MULTU_OP = 8'b0001_1001;
    localparam logic [7:0] EXE_DIV_OP   = 8'b0001_1010;
    localparam logic [7:0] EXE_DIVU_OP  = 8'b0001_1011;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } div_state_e;
endpackage

// File: rtl/hilo_muldiv_unit_div_radix2.sv
// Unsigned restoring radix-2 divider core: one quotient bit per cycle.
module div_radix2 #(
    parameter int DATA_W    = 32,
    parameter int DIV_ITERS = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic [DATA_W-1:0] i_dividend,
    input  logic [DATA_W-1:0] i_divisor,
    output logic              o_last,
    output logic              o_done,
    output logic [DATA_W-1:0] o_quo,
    output logic [DATA_W-1:0] o_rem
);
    localparam int CNT_W = $clog2(DIV_ITERS);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV_ITERS - 1);

    logic              r_busy;
    logic              r_done;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_quo;
    logic [DATA_W-1:0] r_rem;
    logic [DATA_W-1:0] r_div;

    logic [DATA_W:0]   w_sh;
    logic [DATA_W+1:0] w_sub;
    logic              w_ge;

    // Partial remainder shifted left by one with the next dividend bit in.
    assign w_sh  = {r_rem, r_quo[DATA_W-1]};
    assign w_sub = {1'b0, w_sh} - {2'b00, r_div};
    assign w_ge  = ~w_sub[DATA_W+1];

    assign o_last = r_busy & (r_cnt == LAST);
    assign o_done = r_done;
    assign o_quo  = r_quo;
    assign o_rem  = r_rem;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_cnt  <= '0;
            r_quo  <= '0;
            r_rem  <= '0;
            r_div  <= '0;
        end else begin
            r_done <= 1'b0;
            if (i_abort) begin
                r_busy <= 1'b0;
                r_cnt  <= '0;
            end else if (i_start) begin
                r_busy <= 1'b1;
                r_cnt  <= '0;
                r_quo  <= i_dividend;
                r_rem  <= '0;
                r_div  <= i_divisor;
            end else if (r_busy) begin
                r_quo <= {r_quo[DATA_W-2:0], w_ge};
                r_rem <= w_ge ? w_sub[DATA_W-1:0] : w_sh[DATA_W-1:0];
                r_cnt <= r_cnt + 1'b1;
                if (o_last) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/hilo_muldiv_unit.sv
// HI/LO execute unit: single-cycle multiply, iterative divide, MT/MF access.
module hilo_muldiv_unit
    import hilo_muldiv_unit_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int DIV_ITERS = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        alucontrolE,
    input  logic              validE,
    input  logic              flushE,
    input  logic [DATA_W-1:0] srcaE,
    input  logic [DATA_W-1:0] srcbE,
    output logic              stallE,
    output logic [DATA_W-1:0] hilo_rdataE,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);
    div_state_e r_state;
    div_state_e w_next;

    logic [DATA_W-1:0]   r_hi;
    logic [DATA_W-1:0]   r_lo;
    logic                r_neg_q;
    logic                r_neg_r;

    logic                w_go;
    logic                w_is_div;
    logic                w_signed;
    logic                w_bzero;
    logic                w_start;
    logic                w_sa;
    logic                w_sb;
    logic                w_last;
    logic                w_done;
    logic [DATA_W-1:0]   w_mag_a;
    logic [DATA_W-1:0]   w_mag_b;
    logic [DATA_W-1:0]   w_core_quo;
    logic [DATA_W-1:0]   w_core_rem;
    logic [DATA_W-1:0]   w_quo;
    logic [DATA_W-1:0]   w_rem;
    logic [2*DATA_W-1:0] w_prod;

    assign w_go     = validE & ~flushE;
    assign w_is_div = (alucontrolE == EXE_DIV_OP) | (alucontrolE == EXE_DIVU_OP);
    assign w_signed = (alucontrolE == EXE_DIV_OP) | (alucontrolE == EXE_MULT_OP);
    assign w_bzero  = (srcbE == '0);
    assign w_start  = (r_state == S_IDLE) & w_go & w_is_div & ~w_bzero;

    assign w_sa    = w_signed & srcaE[DATA_W-1];
    assign w_sb    = w_signed & srcbE[DATA_W-1];
    assign w_mag_a = w_sa ? -srcaE : srcaE;
    assign w_mag_b = w_sb ? -srcbE : srcbE;

    // Zero/sign extension picks signed or unsigned product from one multiplier.
    assign w_prod = {{DATA_W{w_sa}}, srcaE} * {{DATA_W{w_sb}}, srcbE};

    assign w_quo = r_neg_q ? -w_core_quo : w_core_quo;
    assign w_rem = r_neg_r ? -w_core_rem : w_core_rem;

    assign stallE = (w_start | (r_state == S_BUSY)) & ~flushE & ~rst;

    assign hi_o = r_hi;
    assign lo_o = r_lo;

    always_comb begin
        hilo_rdataE = '0;
        if (alucontrolE == EXE_MFHI_OP) hilo_rdataE = r_hi;
        if (alucontrolE == EXE_MFLO_OP) hilo_rdataE = r_lo;
    end

    div_radix2 #(
        .DATA_W    (DATA_W),
        .DIV_ITERS (DIV_ITERS)
    ) u_div (
        .clk        (clk),
        .rst        (rst),
        .i_start    (w_start),
        .i_abort    (flushE),
        .i_dividend (w_mag_a),
        .i_divisor  (w_mag_b),
        .o_last     (w_last),
        .o_done     (w_done),
        .o_quo      (w_core_quo),
        .o_rem      (w_core_rem)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_start) w_next = S_BUSY;
            S_BUSY:  if (w_last) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (flushE) w_next = S_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_start) begin
                r_neg_q <= w_sa ^ w_sb;
                r_neg_r <= w_sa;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if ((r_state == S_DONE) & w_done & ~flushE) begin
            r_hi <= w_rem;
            r_lo <= w_quo;
        end else if ((r_state == S_IDLE) & w_go) begin
            case (alucontrolE)
                EXE_MULT_OP, EXE_MULTU_OP: {r_hi, r_lo} <= w_prod;
                EXE_DIV_OP, EXE_DIVU_OP: begin
                    if (w_bzero) begin
                        r_hi <= srcaE;
                        r_lo <= '1;
                    end
                end
                EXE_MTHI_OP: r_hi <= srcaE;
                EXE_MTLO_OP: r_lo <= srcaE;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed and randomized checks of hilo_muldiv_unit against an arithmetic model.
module tb_hilo_muldiv_unit;
    import hilo_muldiv_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  alucontrolE;
    logic        validE;
    logic        flushE;
    logic [31:0] srcaE;
    logic [31:0] srcbE;
    logic        stallE;
    logic [31:0] hilo_rdataE;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    int checks = 0;
    int failures = 0;
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    hilo_muldiv_unit dut (
        .clk         (clk),
        .rst         (rst),
        .alucontrolE (alucontrolE),
        .validE      (validE),
        .flushE      (flushE),
        .srcaE       (srcaE),
        .srcbE       (srcbE),
        .stallE      (stallE),
        .hilo_rdataE (hilo_rdataE),
        .hi_o        (hi_o),
        .lo_o        (lo_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: result of one op on the architectural HI/LO pair.
    task automatic model(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        int sa;
        int sb;
        sa = $signed(a);
        sb = $signed(b);
        case (op)
            EXE_MULT_OP: begin
                p = 64'(longint'(sa) * longint'(sb));
                {m_hi, m_lo} = p;
            end
            EXE_MULTU_OP: begin
                p = {32'd0, a} * {32'd0, b};
                {m_hi, m_lo} = p;
            end
            EXE_DIVU_OP: begin
                if (b == 0) begin m_hi = a; m_lo = 32'hFFFF_FFFF; end
                else begin m_lo = a / b; m_hi = a % b; end
            end
            EXE_DIV_OP: begin
                if (b == 0) begin m_hi = a; m_lo = 32'hFFFF_FFFF; end
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    m_lo = 32'h8000_0000; m_hi = 0;
                end else begin
                    m_lo = 32'(sa / sb); m_hi = 32'(sa % sb);
                end
            end
            EXE_MTHI_OP: m_hi = a;
            EXE_MTLO_OP: m_lo = a;
            default: ;
        endcase
    endtask

    // Present one op, wait for it to leave E, compare stall length and HI/LO.
    task automatic issue(input string tag, input logic [7:0] op,
                         input logic [31:0] a, input logic [31:0] b);
        int n;
        int exp_n;
        alucontrolE = op; srcaE = a; srcbE = b; validE = 1'b1; flushE = 1'b0;
        n = 0;
        #1;
        while (stallE && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        validE = 1'b0; alucontrolE = 8'h00;
        model(op, a, b);
        exp_n = ((op == EXE_DIV_OP || op == EXE_DIVU_OP) && b != 0) ? 33 : 0;
        chk({tag, ".stall"}, 32'(n), 32'(exp_n));
        chk({tag, ".hi"}, hi_o, m_hi);
        chk({tag, ".lo"}, lo_o, m_lo);
    endtask

    task automatic read_back(input string tag);
        alucontrolE = EXE_MFHI_OP; #1;
        chk({tag, ".mfhi"}, hilo_rdataE, m_hi);
        alucontrolE = EXE_MFLO_OP; #1;
        chk({tag, ".mflo"}, hilo_rdataE, m_lo);
        alucontrolE = 8'h00; #1;
        chk({tag, ".nop_rd"}, hilo_rdataE, 32'h0);
    endtask

    initial begin
        logic [7:0] ops [6];
        ops[0] = EXE_MULT_OP; ops[1] = EXE_MULTU_OP; ops[2] = EXE_DIV_OP;
        ops[3] = EXE_DIVU_OP; ops[4] = EXE_MTHI_OP;  ops[5] = EXE_MTLO_OP;
        rst = 1'b1; validE = 1'b0; flushE = 1'b0;
        alucontrolE = 8'h00; srcaE = 0; srcbE = 0;
        m_hi = 0; m_lo = 0;
        #1;
        chk("reset.stall", 32'(stallE), 32'd0);
        chk("reset.hi", hi_o, 32'h0);
        chk("reset.lo", lo_o, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        issue("mult", EXE_MULT_OP, 32'hFFFF_FFFE, 32'd3);
        chk("mult.hi_c", hi_o, 32'hFFFF_FFFF);
        chk("mult.lo_c", lo_o, 32'hFFFF_FFFA);
        issue("multu", EXE_MULTU_OP, 32'hFFFF_FFFE, 32'd3);
        chk("multu.hi_c", hi_o, 32'h0000_0002);
        chk("multu.lo_c", lo_o, 32'hFFFF_FFFA);

        issue("divu", EXE_DIVU_OP, 32'd100, 32'd7);
        chk("divu.lo_c", lo_o, 32'd14);
        chk("divu.hi_c", hi_o, 32'd2);
        read_back("divu");

        issue("div_neg", EXE_DIV_OP, 32'hFFFF_FFF9, 32'd2);
        chk("div_neg.lo_c", lo_o, 32'hFFFF_FFFD);
        chk("div_neg.hi_c", hi_o, 32'hFFFF_FFFF);
        issue("div_ovf", EXE_DIV_OP, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("div_ovf.lo_c", lo_o, 32'h8000_0000);
        chk("div_ovf.hi_c", hi_o, 32'h0);
        issue("divu_z", EXE_DIVU_OP, 32'd5, 32'd0);
        chk("divu_z.hi_c", hi_o, 32'd5);
        chk("divu_z.lo_c", lo_o, 32'hFFFF_FFFF);

        issue("mthi", EXE_MTHI_OP, 32'h1234, 32'd0);
        issue("mtlo", EXE_MTLO_OP, 32'h5678, 32'd0);
        alucontrolE = EXE_DIV_OP; srcaE = 32'd1000; srcbE = 32'd3; validE = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
        end
        chk("flush.busy_stall", 32'(stallE), 32'd1);
        flushE = 1'b1; #1;
        chk("flush.stall", 32'(stallE), 32'd0);
        @(posedge clk); #1;
        flushE = 1'b0; validE = 1'b0; #1;
        chk("flush.idle_stall", 32'(stallE), 32'd0);
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
        end
        chk("flush.hi", hi_o, 32'h1234);
        chk("flush.lo", lo_o, 32'h5678);

        alucontrolE = EXE_DIVU_OP; srcaE = 32'd77; srcbE = 32'd5; validE = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
        end
        rst = 1'b1; #1;
        chk("rst_mid.stall", 32'(stallE), 32'd0);
        chk("rst_mid.hi", hi_o, 32'h0);
        chk("rst_mid.lo", lo_o, 32'h0);
        validE = 1'b0; m_hi = 0; m_lo = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        issue("divu_post", EXE_DIVU_OP, 32'd9, 32'd3);
        chk("divu_post.lo_c", lo_o, 32'd3);
        chk("divu_post.hi_c", hi_o, 32'd0);

        for (int i = 0; i < 40; i++) begin
            logic [7:0] op;
            logic [31:0] a;
            logic [31:0] b;
            op = ops[$urandom_range(0, 5)];
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 7) == 0) b = 0;
            if ($urandom_range(0, 5) == 0) b = 32'($urandom_range(1, 15));
            if ($urandom_range(0, 5) == 0) b = -b;
            issue($sformatf("rnd%0d", i), op, a, b);
            if (i % 8 == 0) read_back($sformatf("rnd%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
